// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving the shared 8-bit ALU for shift-by-N, shift-add multiply and compare.
// Optional micro-op counter output OpCount is enabled by defining ALU_SEQ_CYCCNT_EN.
module alu_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       MacroOp,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ALU_InputA,
   output logic [WIDTH-1:0] ALU_InputB,
   output logic [2:0]       ALU_OP,
   output logic             ALU_SC_in,
   input  logic [WIDTH-1:0] ALU_Out,
   input  logic             ALU_Zero
`ifdef ALU_SEQ_CYCCNT_EN
   ,
   output logic [4:0]       OpCount
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StShift,
      StMulAdd,
      StMulShr,
      StMulShl,
      StCmp,
      StDone
   } state_e;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpLsl = 3'b001;
   localparam logic [2:0] OpLsr = 3'b010;
   localparam logic [2:0] OpSeq = 3'b101;

   localparam logic [1:0] MacShl = 2'b00;
   localparam logic [1:0] MacShr = 2'b01;
   localparam logic [1:0] MacMul = 2'b10;
   localparam logic [1:0] MacCmp = 2'b11;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   reg_a_q, reg_a_d;
   logic [WIDTH-1:0]   reg_b_q, reg_b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [1:0]         op_q, op_d;
   logic               issue;
   logic               accept;

   always_comb begin
      state_d    = state_q;
      reg_a_d    = reg_a_q;
      reg_b_d    = reg_b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      op_d       = op_q;
      issue      = 1'b0;
      accept     = 1'b0;
      ALU_InputA = '0;
      ALU_InputB = '0;
      ALU_OP     = OpAdd;

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               accept  = 1'b1;
               reg_a_d = OperandA;
               reg_b_d = OperandB;
               acc_d   = '0;
               cnt_d   = '0;
               op_d    = MacroOp;
               unique case (MacroOp)
                  MacShl, MacShr: begin
                     cnt_d = OperandB[CNT_W-1:0];
                     if (OperandB[CNT_W-1:0] == '0) begin
                        result_d = OperandA;
                        state_d  = StDone;
                     end else begin
                        state_d = StShift;
                     end
                  end
                  MacMul: begin
                     if (OperandB == '0) begin
                        result_d = '0;
                        state_d  = StDone;
                     end else if (OperandB[0]) begin
                        state_d = StMulAdd;
                     end else begin
                        state_d = StMulShr;
                     end
                  end
                  MacCmp: state_d = StCmp;
                  default: state_d = StIdle;
               endcase
            end
         end

         StShift: begin
            issue      = 1'b1;
            ALU_InputA = reg_a_q;
            ALU_OP     = (op_q == MacShr) ? OpLsr : OpLsl;
            reg_a_d    = ALU_Out;
            cnt_d      = cnt_q - CNT_W'(1);
            // Last shift lands directly in Result so it is valid in the DONE cycle.
            if (cnt_q == CNT_W'(1)) begin
               result_d = ALU_Out;
               state_d  = StDone;
            end
         end

         StMulAdd: begin
            issue      = 1'b1;
            ALU_InputA = acc_q;
            ALU_InputB = reg_a_q;
            ALU_OP     = OpAdd;
            acc_d      = ALU_Out;
            state_d    = StMulShr;
         end

         StMulShr: begin
            issue      = 1'b1;
            ALU_InputA = reg_b_q;
            ALU_OP     = OpLsr;
            reg_b_d    = ALU_Out;
            // No multiplier bits left: the accumulator already holds the product.
            if (ALU_Zero) begin
               result_d = acc_q;
               state_d  = StDone;
            end else begin
               state_d = StMulShl;
            end
         end

         StMulShl: begin
            issue      = 1'b1;
            ALU_InputA = reg_a_q;
            ALU_OP     = OpLsl;
            reg_a_d    = ALU_Out;
            state_d    = reg_b_q[0] ? StMulAdd : StMulShr;
         end

         StCmp: begin
            issue      = 1'b1;
            ALU_InputA = reg_a_q;
            ALU_InputB = reg_b_q;
            ALU_OP     = OpSeq;
            result_d   = ALU_Out;
            state_d    = StDone;
         end

         StDone: state_d = StIdle;

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= StIdle;
         reg_a_q  <= '0;
         reg_b_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         reg_a_q  <= reg_a_d;
         reg_b_q  <= reg_b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         op_q     <= op_d;
      end
   end

`ifdef ALU_SEQ_CYCCNT_EN
   logic [4:0] op_cnt_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         op_cnt_q <= '0;
      end else if (accept) begin
         op_cnt_q <= '0;
      end else if (issue) begin
         op_cnt_q <= op_cnt_q + 5'd1;
      end
   end

   assign OpCount = op_cnt_q;
`else
   logic unused_issue;
   assign unused_issue = issue ^ accept;
`endif

   assign Busy      = (state_q != StIdle);
   assign Done      = (state_q == StDone);
   assign Result    = result_q;
   assign ALU_SC_in = 1'b0;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that drives the shared 8-bit ALU (ADD/LSL/LSR/XOR/SNE/SEQ/MSK) to execute macro-operations: shift-by-N, 8x8 shift-add multiply and equality compare. It sits between the control unit and the ALU, owns the ALU input and opcode ports while busy, and returns an 8-bit result with a Start/Done handshake.

Parameters:
WIDTH, 8, datapath width; must match the ALU (only 8 is supported).
CNT_W, 3, width of the shift-count field taken from OperandB[CNT_W-1:0].

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
MacroOp  input  2  00 SHL, 01 SHR, 10 MUL, 11 CMP
OperandA  input  8  first operand; latched on an accepted Start
OperandB  input  8  second operand, or shift count in [2:0]; latched on an accepted Start
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when Result is valid
Result  output  8  registered result; holds until the next accepted Start
ALU_InputA  output  8  to ALU InputA
ALU_InputB  output  8  to ALU InputB
ALU_OP  output  3  to ALU OP
ALU_SC_in  output  1  to ALU SC_in; always 0
ALU_Out  input  8  from ALU Out (combinational)
ALU_Zero  input  1  from ALU Zero (ALU_Out == 0)

Behaviour:
- Reset (synchronous, may occur mid-operation): FSM returns to IDLE. Busy=0, Done=0, Result=0. All internal registers clear. ALU outputs are 0 with ALU_OP=000. No Done is produced for an aborted op.
- In IDLE the ALU ports are driven to 0 with OP=000.
- States: IDLE, SHIFT, MUL_ADD, MUL_SHR, MUL_SHL, CMP, DONE.
- One ALU micro-op is issued per cycle. ALU_Out is captured into the working register at the next edge.
- IDLE: when Start=1, latch OperandA into regA and OperandB into regB. Clear acc and cnt, then branch:
  - SHL/SHR: cnt = OperandB[2:0]. If cnt=0, go to DONE with Result=regA. Otherwise go to SHIFT.
  - MUL: if OperandB=0, go to DONE with Result=0. Otherwise go to MUL_ADD if OperandB[0]=1, else MUL_SHR.
  - CMP: go to CMP.
- SHIFT: issue LSL (SHL) or LSR (SHR) on regA with B=0. regA<=ALU_Out and cnt decrements. Leave for DONE when cnt reaches 0.
- MUL_ADD: issue ADD(acc, regA); acc<=ALU_Out (mod 256, carry discarded). Next state is MUL_SHR.
- MUL_SHR: issue LSR on regB; regB<=ALU_Out.
  - If ALU_Zero=1, go to DONE with Result=acc (early exit).
  - Otherwise go to MUL_SHL.
- MUL_SHL: issue LSL on regA; regA<=ALU_Out. Next state is MUL_ADD if regB[0]=1, else MUL_SHR.
- CMP: issue SEQ(regA, regB); Result<=ALU_Out, then go to DONE.
- DONE: Done=1 for exactly one cycle, Busy=1, then go to IDLE. Result is already valid in this cycle.
- Latency: for k ALU micro-ops, Done is high in cycle k+1 after the accepting edge. k=0 for the immediate cases.
- Simultaneous/boundary cases:
  - Start while Busy=1 is ignored; operands are not re-latched.
  - Start in the same cycle as Reset is ignored.
  - Start asserted during the DONE cycle is ignored. The earliest accept is the first IDLE cycle after DONE.
  - MUL result is the low 8 bits of the product.
  - Worst-case MUL (B=0xFF) takes 23 micro-ops: 8 ADD, 8 LSR, 7 LSL.

Optional Feature:
- Macro ALU_SEQ_CYCCNT_EN.
- When defined: adds output OpCount (5 bits).
  - Clears on an accepted Start and increments once per issued ALU micro-op.
  - Holds its value from DONE until the next accepted Start. Reset value is 0.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- SHL, A=0x03, B=0x02 -> ALU_OP=001 for 2 cycles; Done in cycle 3 after accept; Result=0x0C; OpCount=2.
- MUL, A=5, B=3 -> op order ADD, LSR, LSL, ADD, LSR; Result=0x0F; Done in cycle 6; OpCount=5. MUL, A=0xFF, B=0xFF -> Result=0x01; OpCount=23.
- MUL, A=0x10, B=0x20 -> Result=0x00 (truncated). MUL, A=9, B=0 -> Result=0, Done in cycle 1, OpCount=0.
- CMP, A=5, B=5 -> Result=1. CMP, A=0, B=1 -> Result=0. Each takes 1 micro-op with ALU_OP=101.
- SHR, A=0x80, B=0 -> Result=0x80 in cycle 1. Start pulsed while Busy with different operands -> ignored; the first op's Result is unchanged.
- Reset asserted in the 3rd cycle of MUL A=7, B=0xFF -> next cycle Busy=0, Done=0, Result=0, ALU ports 0. A following CMP 4,4 completes normally with Result=1.
